offchip_loader: RTL and testbench

Burst loader that streams 32-bit words from an off-chip source into one scratchpad bank. It drives the scratchpad `off_chip_bus` port. It writes consecutive bank addresses starting from a configured base. A small FIFO absorbs cycles where the scratchpad arbiter stalls the off-chip port. The block sits between the off-chip memory interface and `scratchpad`, alongside the LSUs.

---
 rtl/offchip_loader.sv | 134 +++++++++++++
 tb/tb_offchip_loader.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/offchip_loader.sv
// Burst loader: streams off-chip words through a small FIFO into consecutive
// scratchpad bank addresses via the scratchpad off-chip write port.
module offchip_loader #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  cfg_bank,
  input  logic [7:0]  cfg_base,
  input  logic [7:0]  cfg_len,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  input  logic        stall,
  output logic [43:0] off_chip_bus,
  output logic        busy,
  output logic        done
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e            state_q;
  logic [1:0]        bank_q;
  logic [7:0]        base_q;
  logic [8:0]        len_q;
  logic [8:0]        acc_q;
  logic [8:0]        iss_q;
  logic [31:0]       mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic [43:0]       bus_q;
  logic              busy_q;
  logic              done_q;

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic last_issue;

  assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  // in_ready ignores a same-cycle pop, so a full FIFO never takes a word.
  assign in_ready   = (state_q == StLoad) && !fifo_full && (acc_q < len_q);
  assign push       = in_valid && in_ready;
  assign pop        = (state_q == StLoad) && !fifo_empty && !stall;
  assign last_issue = pop && ((iss_q + 9'd1) == len_q);

  assign off_chip_bus = bus_q;
  assign busy         = busy_q;
  assign done         = done_q;

  // Data storage needs no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      bank_q   <= '0;
      base_q   <= '0;
      len_q    <= '0;
      acc_q    <= '0;
      iss_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      bus_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      bus_q  <= '0;
      done_q <= 1'b0;

      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
        acc_q    <= acc_q + 9'd1;
      end

      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
        iss_q    <= iss_q + 9'd1;
        bus_q    <= {bank_q, 1'b1, 1'b1, base_q + iss_q[7:0], mem_q[rd_ptr_q]};
      end

      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase

      unique case (state_q)
        StIdle: begin
          if (start) begin
            bank_q   <= cfg_bank;
            base_q   <= cfg_base;
            len_q    <= (cfg_len == 8'd0) ? 9'd256 : {1'b0, cfg_len};
            acc_q    <= '0;
            iss_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= StLoad;
          end
        end
        StLoad: begin
          if (last_issue) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_offchip_loader.sv
// Randomised bench for offchip_loader with a queue-based transaction model.
module tb_offchip_loader;
  localparam int unsigned FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  cfg_bank;
  logic [7:0]  cfg_base;
  logic [7:0]  cfg_len;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        stall;
  logic [43:0] off_chip_bus;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  offchip_loader #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_bank(cfg_bank), .cfg_base(cfg_base),
    .cfg_len(cfg_len), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .stall(stall), .off_chip_bus(off_chip_bus), .busy(busy), .done(done)
  );

  // Model: a burst is a list of accepted words written to base+i in order.
  bit          m_load, m_done;
  int          m_acc, m_iss, m_len;
  logic [1:0]  m_bank;
  logic [7:0]  m_base;
  logic [43:0] m_bus;
  logic [31:0] m_q[$];

  // Observations of DUT writes.
  int         writes, addr_dup;
  logic [7:0] obs_addr[$];
  bit         addr_seen[256];

  function automatic logic [46:0] exp_vec();
    return {m_bus, m_load && (m_q.size() < FIFO_DEPTH) && (m_acc < m_len), m_load || m_done,
            m_done};
  endfunction

  function automatic logic [46:0] obs_vec();
    return {off_chip_bus, in_ready, busy, done};
  endfunction

  function automatic bit pct(input int p);
    return $urandom_range(99) < p;
  endfunction

  task automatic clear_obs();
    writes = 0;
    addr_dup = 0;
    obs_addr.delete();
    foreach (addr_seen[i]) addr_seen[i] = 1'b0;
  endtask

  // One clock: drive inputs at the falling edge, advance model, sample at next falling edge.
  task automatic step(input logic st, input logic [1:0] b, input logic [7:0] ba,
                      input logic [7:0] ln, input logic v, input logic [31:0] d, input logic s);
    logic ready, idle, issue, push;
    ready = m_load && (m_q.size() < FIFO_DEPTH) && (m_acc < m_len);
    idle  = !m_load && !m_done;
    start = st; cfg_bank = b; cfg_base = ba; cfg_len = ln;
    in_valid = v; in_data = d; stall = s;
    @(posedge clk);
    issue = m_load && (m_q.size() > 0) && !s;
    push  = v && ready;
    m_bus  = '0;
    m_done = 1'b0;
    if (issue) begin
      m_bus = {m_bank, 2'b11, 8'(m_base + m_iss[7:0]), m_q.pop_front()};
      m_iss++;
      if (m_iss == m_len) begin
        m_load = 1'b0;
        m_done = 1'b1;
      end
    end
    if (push) begin
      m_q.push_back(d);
      m_acc++;
    end
    if (idle && st) begin
      m_load = 1'b1; m_bank = b; m_base = ba; m_len = (ln == 8'd0) ? 256 : int'(ln);
      m_acc = 0; m_iss = 0;
    end
    @(negedge clk);
    if (off_chip_bus[41]) begin
      writes++;
      obs_addr.push_back(off_chip_bus[39:32]);
      if (addr_seen[off_chip_bus[39:32]]) addr_dup++;
      addr_seen[off_chip_bus[39:32]] = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; stall = 1'b0;
    @(posedge clk);
    m_load = 0; m_done = 0; m_bus = '0; m_q.delete(); m_acc = 0; m_iss = 0; m_len = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    do_reset();
    checks++;
    if (obs_vec() !== 47'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0", obs_vec());
    end
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL reset_model got=%h want=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_basic();
    clear_obs();
    step(1'b1, 2'd1, 8'h10, 8'd3, 1'b0, 32'h0, 1'b0);
    for (int c = 0; c < 20 && (m_load || m_done); c++) begin
      step(1'b0, 2'd0, 8'h0, 8'h0, m_acc < 3, 32'hA + 32'(m_acc), 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL basic cyc=%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (writes !== 3 || m_load || m_done) begin
      failures++;
      $display("FAIL basic_count got=%0d want=3", writes);
    end
  endtask

  task automatic test_stall();
    logic [7:0] base;
    base = 8'($urandom);
    clear_obs();
    step(1'b1, 2'd2, base, 8'd8, 1'b0, 32'h0, 1'b0);
    step(1'b0, 2'd0, 8'h0, 8'h0, 1'b1, $urandom, 1'b0);
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 2'd0, 8'h0, 8'h0, 1'b1, $urandom, 1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (in_ready !== 1'b0 || writes !== 0) begin
      failures++;
      $display("FAIL stall_full in_ready=%b writes=%0d want in_ready=0 writes=0",
               in_ready, writes);
    end
    for (int c = 0; c < 40 && (m_load || m_done); c++) begin
      step(1'b0, 2'd0, 8'h0, 8'h0, 1'b1, $urandom, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL stall_drain cyc=%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (writes !== 8 || addr_dup !== 0 || m_load || m_done) begin
      failures++;
      $display("FAIL stall_count got=%0d dup=%0d want=8 dup=0", writes, addr_dup);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] want [4];
    want = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    clear_obs();
    step(1'b1, 2'd3, 8'hFE, 8'd4, 1'b0, 32'h0, 1'b0);
    for (int c = 0; c < 100 && (m_load || m_done); c++) begin
      step(1'b0, 2'd0, 8'h0, 8'h0, pct(60), $urandom, pct(30));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL wrap cyc=%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (obs_addr.size() !== 4) begin
      failures++;
      $display("FAIL wrap_count got=%0d want=4", obs_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_addr[i] !== want[i]) begin
          failures++;
          $display("FAIL wrap_addr idx=%0d got=%h want=%h", i, obs_addr[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_len_zero();
    int missing;
    clear_obs();
    step(1'b1, 2'd0, 8'($urandom), 8'd0, 1'b0, 32'h0, 1'b0);
    for (int c = 0; c < 3000 && (m_load || m_done); c++) begin
      step(1'b0, 2'd0, 8'h0, 8'h0, pct(80), $urandom, pct(20));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL len0 cyc=%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
    end
    missing = 0;
    foreach (addr_seen[i]) if (!addr_seen[i]) missing++;
    checks++;
    if (writes !== 256 || addr_dup !== 0 || missing !== 0 || m_load || m_done) begin
      failures++;
      $display("FAIL len0_cover writes=%0d dup=%0d missing=%0d want 256/0/0",
               writes, addr_dup, missing);
    end
  endtask

  task automatic test_start_while_busy();
    clear_obs();
    step(1'b1, 2'd2, 8'h30, 8'd6, 1'b0, 32'h0, 1'b0);
    for (int c = 0; c < 60 && (m_load || m_done); c++) begin
      if (c == 3 || c == 5)
        step(1'b1, 2'd3, 8'h80, 8'd2, pct(70), $urandom, pct(20));
      else
        step(1'b0, 2'd0, 8'h0, 8'h0, pct(70), $urandom, pct(20));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL busy_start cyc=%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (writes !== 6 || obs_addr[0] !== 8'h30) begin
      failures++;
      $display("FAIL busy_start_count got=%0d first=%h want=6 first=30", writes, obs_addr[0]);
    end
  endtask

  task automatic test_reset_mid_burst();
    clear_obs();
    step(1'b1, 2'd1, 8'($urandom), 8'd5, 1'b0, 32'h0, 1'b0);
    for (int c = 0; c < 30 && writes < 2; c++)
      step(1'b0, 2'd0, 8'h0, 8'h0, 1'b1, $urandom, 1'b0);
    do_reset();
    checks++;
    if (off_chip_bus !== 44'd0 || busy !== 1'b0 || in_ready !== 1'b0 || writes !== 2) begin
      failures++;
      $display("FAIL reset_mid bus=%h busy=%b in_ready=%b writes=%0d want 0/0/0/2",
               off_chip_bus, busy, in_ready, writes);
    end
    clear_obs();
    step(1'b1, 2'd0, 8'h40, 8'd3, 1'b0, 32'h0, 1'b0);
    for (int c = 0; c < 40 && (m_load || m_done); c++) begin
      step(1'b0, 2'd0, 8'h0, 8'h0, pct(70), $urandom, pct(20));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL reset_restart cyc=%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (writes !== 3 || obs_addr[0] !== 8'h40) begin
      failures++;
      $display("FAIL reset_restart_count got=%0d first=%h want=3 first=40", writes, obs_addr[0]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      int vp, sp;
      vp = $urandom_range(30, 100);
      sp = $urandom_range(0, 60);
      step(1'b1, 2'($urandom), 8'($urandom), 8'($urandom_range(1, 24)), 1'b0, 32'h0, 1'b0);
      for (int c = 0; c < 1000 && (m_load || m_done); c++) begin
        step(pct(10), 2'($urandom), 8'($urandom), 8'($urandom), pct(vp), $urandom, pct(sp));
        checks++;
        if (obs_vec() !== exp_vec()) begin
          failures++;
          $display("FAIL random burst=%0d cyc=%0d got=%h want=%h", n, c, obs_vec(), exp_vec());
        end
      end
      checks++;
      if (m_load || m_done) begin
        failures++;
        $display("FAIL random_timeout burst=%0d got=busy want=idle", n);
      end
      step(1'b0, 2'd0, 8'h0, 8'h0, 1'b0, 32'h0, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_bank = '0; cfg_base = '0; cfg_len = '0;
    in_valid = 1'b0; in_data = '0; stall = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_len_zero();
    test_start_while_busy();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
